// File: rtl/sd_tx_ctrl.sv
// sd_tx_ctrl: SD data-line Tx frame sequencer (start token, data, CRC16 hi/lo, end byte).
// Define TX_UNDERRUN_ABORT_EN to abort the frame on a FIFO underrun instead of sending fill bytes.
module sd_tx_ctrl #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W = $clog2(BLOCK_BYTES + 1)
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic       start_i,
  input  logic       load_enable_i,
  input  logic       fifo_empty_i,
  output logic       sending_o,
  output logic       sd_enable_o,
  output logic [2:0] byte_sel_o,
  output logic       load_first_o,
  output logic       fifo_pop_o,
  output logic       crc_clear_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       underrun_o
);
`ifdef TX_UNDERRUN_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, FIRST, SYNC, DATA, CRCH, CRCL, ENDB} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sending_q, sd_en_q, first_q, underrun_q;
  logic             more, data_sel, ld_data, und;
  assign more     = cnt_q < CNT_W'(BLOCK_BYTES);
  // A data byte is due at the next load in SYNC, and in DATA until the block is complete.
  assign data_sel = state_q == SYNC || (state_q == DATA && more);
  assign ld_data  = load_enable_i && data_sel;
  assign und      = ld_data && fifo_empty_i;
  always_comb begin
    byte_sel_o = 3'd0;
    case (state_q)
      FIRST:      byte_sel_o = 3'd1;
      SYNC, DATA: byte_sel_o = !data_sel ? 3'd3 : fifo_empty_i ? 3'd6 : 3'd2;
      CRCH:       byte_sel_o = 3'd4;
      CRCL:       byte_sel_o = 3'd5;
      default:    byte_sel_o = 3'd0;
    endcase
  end
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sending_q  <= 1'b0;
      sd_en_q    <= 1'b0;
      first_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (und) underrun_q <= 1'b1;
      case (state_q)
        IDLE: if (start_i) begin
          state_q    <= FIRST;
          first_q    <= 1'b1;
          sending_q  <= 1'b1;
          underrun_q <= 1'b0;
        end
        FIRST: state_q <= SYNC;
        SYNC: if (load_enable_i) begin
          state_q <= DATA;
          sd_en_q <= 1'b1;
          cnt_q   <= CNT_W'(1);
        end
        DATA: if (load_enable_i) begin
          if (more) cnt_q <= cnt_q + CNT_W'(1);
          else begin
            state_q <= CRCH;
            sd_en_q <= 1'b0;
          end
        end
        CRCH: if (load_enable_i) state_q <= CRCL;
        CRCL: if (load_enable_i) state_q <= ENDB;
        ENDB: if (load_enable_i) begin
          state_q   <= IDLE;
          sending_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      // Abort overrides whatever the data/sync branch scheduled above.
      if (ABORT && und) begin
        state_q   <= IDLE;
        sending_q <= 1'b0;
        sd_en_q   <= 1'b0;
      end
    end
  assign sending_o    = sending_q;
  assign busy_o       = sending_q;
  assign sd_enable_o  = sd_en_q;
  assign load_first_o = first_q;
  assign crc_clear_o  = first_q;
  assign fifo_pop_o   = ld_data && !fifo_empty_i;
  assign tx_done_o    = (load_enable_i && state_q == ENDB) || (ABORT && und);
  assign underrun_o   = underrun_q || und;
endmodule

// File: tb/tb_sd_tx_ctrl.sv
// tb_sd_tx_ctrl: frame-level checks of sd_tx_ctrl with BLOCK_BYTES=4 against a load-sequence model.
module tb_sd_tx_ctrl;
  localparam int BB = 4;
`ifdef TX_UNDERRUN_ABORT_EN
  localparam bit AB = 1'b1;
`else
  localparam bit AB = 1'b0;
`endif
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, le = 1'b0, fe = 1'b0;
  logic sending, sd_en, load_first, fifo_pop, crc_clear, busy, tx_done, underrun;
  logic [2:0] byte_sel;
  int checks = 0, failures = 0, n_clr = 0, n_start = 0;

  sd_tx_ctrl #(.BLOCK_BYTES(BB)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .load_enable_i(le), .fifo_empty_i(fe),
    .sending_o(sending), .sd_enable_o(sd_en), .byte_sel_o(byte_sel), .load_first_o(load_first),
    .fifo_pop_o(fifo_pop), .crc_clear_o(crc_clear), .busy_o(busy), .tx_done_o(tx_done),
    .underrun_o(underrun)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (crc_clear) n_clr++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Source expected at load i of a frame (i=0 is the SYNC load carrying data byte 1).
  function automatic logic [2:0] m_sel(input int i, input logic e);
    if (i < BB) return e ? 3'd6 : 3'd2;
    return i == BB ? 3'd3 : i == BB + 1 ? 3'd4 : i == BB + 2 ? 3'd5 : 3'd0;
  endfunction

  function automatic int m_last(input logic [BB-1:0] m);
    m_last = BB + 3;
    if (AB) for (int k = BB - 1; k >= 0; k--) if (m[k]) m_last = k;
  endfunction

  task automatic frame(input logic [BB-1:0] m, input int gap, input bit poke, input bit pre,
                       input bit chain, input int cut,
                       output int pops, output int sds, output bit und, output int loads);
    int last;
    bit seen;
    last = m_last(m); seen = 0; pops = 0; sds = 0; loads = 0; und = 0;
    if (!pre) begin
      @(negedge clk); start = 1; le = 1'($urandom); fe = 1'($urandom);
      #1 chk("idle_busy", busy, 0); chk("idle_pop", fifo_pop, 0);
      chk("idle_done", tx_done, 0); chk("idle_sel", byte_sel, 0);
    end
    n_start++;
    @(negedge clk); start = 0; le = 1'($urandom); fe = 1'($urandom);
    #1 chk("first_ld", load_first, 1); chk("first_clr", crc_clear, 1); chk("first_sel", byte_sel, 1);
    chk("first_send", sending, 1); chk("first_pop", fifo_pop, 0); chk("first_und", underrun, 0);
    for (int i = 0; i <= last; i++) begin
      if (i == cut) return;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); le = 0; fe = 1'($urandom); start = poke & 1'($urandom);
        #1 chk("gap_send", sending, 1); chk("gap_sd", sd_en, i >= 1 && i <= BB);
        chk("gap_sel", byte_sel, m_sel(i, fe)); chk("gap_pop", fifo_pop, 0); chk("gap_done", tx_done, 0);
      end
      @(negedge clk); le = 1; fe = i < BB ? m[i] : 1'($urandom);
      start = poke & ((i == last) | 1'($urandom));
      seen |= i < BB && m[i];
      #1 chk("ld_sel", byte_sel, m_sel(i, fe)); chk("ld_pop", fifo_pop, i < BB && !m[i]);
      chk("ld_done", tx_done, i == last); chk("ld_sd", sd_en, i >= 1 && i <= BB);
      chk("ld_und", underrun, seen);
      pops += fifo_pop; sds += sd_en; loads++;
    end
    @(negedge clk); le = 0; start = chain;
    #1 chk("end_send", sending, 0); chk("end_busy", busy, 0); chk("end_sel", byte_sel, 0);
    chk("end_und", underrun, seen);
    und = underrun;
  endtask

  typedef struct {
    logic [BB-1:0] m;
    int gap;
    bit poke;
    int pops;
    int sds;
    bit und;
    int loads;
  } vec_t;
  vec_t tv[8];

  initial begin
    int p, s, l, last, ep, es;
    bit u;
    logic [BB-1:0] m;
    tv[0] = '{4'b0000, 0, 1'b0, 4, 4, 1'b0, 8};
    tv[1] = '{4'b0000, 3, 1'b1, 4, 4, 1'b0, 8};
    tv[2] = '{4'b0100, 1, 1'b0, AB ? 2 : 3, AB ? 2 : 4, 1'b1, AB ? 3 : 8};
    tv[3] = '{4'b0000, 2, 1'b1, 4, 4, 1'b0, 8};
    tv[4] = '{4'b0001, 2, 1'b0, AB ? 0 : 3, AB ? 0 : 4, 1'b1, AB ? 1 : 8};
    tv[5] = '{4'b1000, 0, 1'b1, 3, AB ? 3 : 4, 1'b1, AB ? 4 : 8};
    tv[6] = '{4'b1111, 1, 1'b0, 0, AB ? 0 : 4, 1'b1, AB ? 1 : 8};
    tv[7] = '{4'b0000, 1, 1'b0, 4, 4, 1'b0, 8};
    #2 chk("reset_outs", {sending, sd_en, byte_sel, load_first, fifo_pop, crc_clear, busy, tx_done, underrun}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1;
    foreach (tv[k]) begin
      frame(tv[k].m, tv[k].gap, tv[k].poke, 0, 0, -1, p, s, u, l);
      chk("tv_pops", p, tv[k].pops); chk("tv_sd", s, tv[k].sds);
      chk("tv_und", u, tv[k].und); chk("tv_loads", l, tv[k].loads);
    end
    frame('0, 1, 1, 0, 1, -1, p, s, u, l);
    frame('0, 0, 0, 1, 0, -1, p, s, u, l);
    chk("b2b_pops", p, 4); chk("b2b_loads", l, 8);
    frame('0, 1, 0, 0, 0, BB + 1, p, s, u, l);
    @(posedge clk);
    #1 le = 0;
    chk("pre_rst_crch", byte_sel, 4);
    #1 n_rst = 0;
    #1 chk("mid_rst_outs", {sending, sd_en, byte_sel, load_first, fifo_pop, crc_clear, busy, tx_done, underrun}, 0);
    @(negedge clk); n_rst = 1;
    frame('0, 2, 0, 0, 0, -1, p, s, u, l);
    chk("post_rst_pops", p, 4); chk("post_rst_und", u, 0); chk("post_rst_loads", l, 8);
    repeat (20) begin
      m = ($urandom_range(0, 2) == 0) ? BB'($urandom) : '0;
      frame(m, $urandom_range(0, 3), 1'($urandom), 0, 0, -1, p, s, u, l);
      last = m_last(m); ep = 0; es = 0;
      for (int i = 0; i <= last; i++) begin
        if (i < BB && !m[i]) ep++;
        if (i >= 1 && i <= BB) es++;
      end
      chk("rnd_pops", p, ep); chk("rnd_sd", s, es); chk("rnd_und", u, m != 0); chk("rnd_loads", l, last + 1);
    end
    chk("crc_clear_count", n_clr, n_start);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
